// File: rtl/link_stack_pkg.sv
// ---------------------------------------------------------------------------
// link_stack_pkg
//   Shared sequence-control constants for the hardware return-address stack,
//   plus small ring-index helpers used by the pointer logic.
//
//   Contents:
//     LINK_STACK_DEPTH  default number of stack entries
//     PC_SRC_STACK      PC source mux select value for "return from stack"
//     ring_inc/ring_dec index arithmetic with explicit wrap for any depth
// ---------------------------------------------------------------------------
package link_stack_pkg;

    localparam int LINK_STACK_DEPTH = 8;
    localparam logic [1:0] PC_SRC_STACK = 2'd3;

    // Depth need not be a power of two, so wrap explicitly instead of
    // relying on natural modulo-2^n overflow.
    function automatic int ring_inc(input int idx, input int depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

    function automatic int ring_dec(input int idx, input int depth);
        return (idx == 0) ? depth - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/link_stack_mem.sv
// ---------------------------------------------------------------------------
// link_stack_mem
//   Depth x DataWidth register array backing the return-address stack.
//   One synchronous write port and one asynchronous read port; contents are
//   never reset.
//
//   Ports:
//     clk      in   rising-edge clock for the write port
//     wr_en    in   write enable
//     wr_addr  in   write index (0..Depth-1)
//     wr_data  in   data to write
//     rd_addr  in   read index (0..Depth-1)
//     rd_data  out  combinational read data
// ---------------------------------------------------------------------------
module link_stack_mem #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/link_stack.sv
// ---------------------------------------------------------------------------
// link_stack
//   Hardware return-address stack (LIFO) for the A09-family CPU. Pushed on a
//   linked jump, popped on RET; the top entry feeds the PC source mux.
//
//   Configuration macro:
//     LINK_STACK_WRAP_EN  defined   -> push while Full overwrites the oldest
//                                      entry (newest kept, Count stays Depth)
//                         undefined -> push while Full is dropped
//
//   Ports:
//     Clk        in   system clock, rising edge
//     Reset      in   synchronous active-low reset
//     Push       in   push DIn this cycle
//     Pop        in   pop top entry this cycle
//     DIn        in   return address to push
//     ErrClr     in   clear sticky Overflow/Underflow
//     DOut       out  top of stack, 0 when empty
//     Count      out  number of valid entries, 0..Depth
//     Empty      out  Count == 0
//     Full       out  Count == Depth
//     Overflow   out  sticky: push attempted while Full
//     Underflow  out  sticky: pop attempted while Empty
// ---------------------------------------------------------------------------
module link_stack
    import link_stack_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Depth     = LINK_STACK_DEPTH,
    parameter int CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Push,
    input  logic                 Pop,
    input  logic [DataWidth-1:0] DIn,
    input  logic                 ErrClr,
    output logic [DataWidth-1:0] DOut,
    output logic [CntWidth-1:0]  Count,
    output logic                 Empty,
    output logic                 Full,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int IdxWidth = $clog2(Depth);

    logic [IdxWidth-1:0]  tp;
    logic [IdxWidth-1:0]  tp_next;
    logic [IdxWidth-1:0]  tp_inc;
    logic [IdxWidth-1:0]  top_idx;
    logic [IdxWidth-1:0]  wr_addr;
    logic [CntWidth-1:0]  count_q;
    logic [CntWidth-1:0]  count_next;
    logic [DataWidth-1:0] rd_data;
    logic                 wr_en;
    logic                 ovf_set;
    logic                 unf_set;
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 is_empty;
    logic                 is_full;

    // tp is the next free slot; the top entry lives one slot below it.
    assign tp_inc   = IdxWidth'(ring_inc(int'(tp), Depth));
    assign top_idx  = IdxWidth'(ring_dec(int'(tp), Depth));
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CntWidth'(Depth));

    // Operation decode. Push&Pop on a non-empty stack is a replace-top;
    // on an empty stack it degrades to a push and still flags underflow.
    // Since Depth >= 2, an empty stack can never also be full.
    always_comb begin
        tp_next    = tp;
        count_next = count_q;
        wr_en      = 1'b0;
        wr_addr    = tp;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (Push && Pop && !is_empty) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (Push && !is_full) begin
            wr_en      = 1'b1;
            tp_next    = tp_inc;
            count_next = count_q + CntWidth'(1);
            unf_set    = Pop;
        end else if (Push) begin
            ovf_set = 1'b1;
`ifdef LINK_STACK_WRAP_EN
            // Overwrite the oldest entry: the slot after the top is the
            // bottom of a full ring.
            wr_en   = 1'b1;
            tp_next = tp_inc;
`endif
        end else if (Pop && !is_empty) begin
            tp_next    = top_idx;
            count_next = count_q - CntWidth'(1);
        end else if (Pop) begin
            unf_set = 1'b1;
        end
    end

    // Pointer, count and sticky flags. A fresh error in the same cycle as
    // ErrClr keeps its flag set.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            tp          <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tp          <= tp_next;
            count_q     <= count_next;
            overflow_q  <= ovf_set | (overflow_q & ~ErrClr);
            underflow_q <= unf_set | (underflow_q & ~ErrClr);
        end
    end

    // Writes are suppressed during reset so a push in that cycle is lost.
    link_stack_mem #(
        .DataWidth(DataWidth),
        .Depth    (Depth),
        .AddrWidth(IdxWidth)
    ) u_mem (
        .clk    (Clk),
        .wr_en  (wr_en & Reset),
        .wr_addr(wr_addr),
        .wr_data(DIn),
        .rd_addr(top_idx),
        .rd_data(rd_data)
    );

    assign DOut      = is_empty ? '0 : rd_data;
    assign Count     = count_q;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_link_stack.sv
// ---------------------------------------------------------------------------
// tb_link_stack
//   Self-checking bench for link_stack (default 8 x 8). A queue-based model
//   tracks the stack contents and sticky flags; a compare process checks the
//   DUT against it on every falling edge, and directed sequences pin the
//   model with hand-computed values. Honors LINK_STACK_WRAP_EN.
// ---------------------------------------------------------------------------
module tb_link_stack;

    localparam int Depth = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Push = 1'b0;
    logic       Pop = 1'b0;
    logic [7:0] DIn = 8'h00;
    logic       ErrClr = 1'b0;
    logic [7:0] DOut;
    logic [3:0] Count;
    logic       Empty;
    logic       Full;
    logic       Overflow;
    logic       Underflow;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    logic [7:0] modelQ[$];
    bit         modelOvf = 1'b0;
    bit         modelUnf = 1'b0;

    link_stack dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Push     (Push),
        .Pop      (Pop),
        .DIn      (DIn),
        .ErrClr   (ErrClr),
        .DOut     (DOut),
        .Count    (Count),
        .Empty    (Empty),
        .Full     (Full),
        .Overflow (Overflow),
        .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: the stack is a queue whose back is the top.
    always @(posedge Clk) begin
        bit newOvf;
        bit newUnf;
        newOvf = 1'b0;
        newUnf = 1'b0;
        if (!Reset) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            if (Push && Pop) begin
                if (modelQ.size() > 0) begin
                    modelQ[modelQ.size() - 1] = DIn;
                end else begin
                    modelQ.push_back(DIn);
                    newUnf = 1'b1;
                end
            end else if (Push) begin
                if (modelQ.size() < Depth) begin
                    modelQ.push_back(DIn);
                end else begin
                    newOvf = 1'b1;
`ifdef LINK_STACK_WRAP_EN
                    void'(modelQ.pop_front());
                    modelQ.push_back(DIn);
`endif
                end
            end else if (Pop) begin
                if (modelQ.size() > 0) begin
                    void'(modelQ.pop_back());
                end else begin
                    newUnf = 1'b1;
                end
            end
            modelOvf = newOvf | (modelOvf & !ErrClr);
            modelUnf = newUnf | (modelUnf & !ErrClr);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (checkEn) begin
            int expTop;
            expTop = (modelQ.size() > 0) ? int'(modelQ[modelQ.size() - 1]) : 0;
            checkOutput("cmp_dout", int'(DOut), expTop);
            checkOutput("cmp_count", int'(Count), modelQ.size());
            checkOutput("cmp_empty", int'(Empty), int'(modelQ.size() == 0));
            checkOutput("cmp_full", int'(Full), int'(modelQ.size() == Depth));
            checkOutput("cmp_ovf", int'(Overflow), int'(modelOvf));
            checkOutput("cmp_unf", int'(Underflow), int'(modelUnf));
        end
    end

    // Drive one cycle of inputs on the falling edge, return just after the
    // following rising edge so literal checks see the updated state.
    task automatic applyStimulus(input bit push, input bit pop, input logic [7:0] din,
                                 input bit errClr, input bit resetN);
        @(negedge Clk);
        Push   = push;
        Pop    = pop;
        DIn    = din;
        ErrClr = errClr;
        Reset  = resetN;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkState(input string tag, input int expCount, input int expDout);
        checkOutput({tag, "_count"}, int'(Count), expCount);
        checkOutput({tag, "_dout"}, int'(DOut), expDout);
    endtask

    initial begin
        int bias;
        // Reset held for two cycles
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkEn = 1'b1;
        checkState("reset", 0, 0);
        checkOutput("reset_empty", int'(Empty), 1);
        checkOutput("reset_full", int'(Full), 0);
        checkOutput("reset_ovf", int'(Overflow), 0);
        checkOutput("reset_unf", int'(Underflow), 0);

        // Basic LIFO order
        applyStimulus(1, 0, 8'h10, 0, 1);
        checkState("push10", 1, 8'h10);
        applyStimulus(1, 0, 8'h20, 0, 1);
        applyStimulus(1, 0, 8'h30, 0, 1);
        checkState("push30", 3, 8'h30);
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkState("pop1", 2, 8'h20);
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkState("pop2", 1, 8'h10);
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkState("pop3", 0, 8'h00);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 0, 8'(i), 0, 1);
        end
        checkOutput("fill_full", int'(Full), 1);
        checkOutput("fill_ovf_before", int'(Overflow), 0);
        applyStimulus(1, 0, 8'h09, 0, 1);
        checkOutput("ovf_set", int'(Overflow), 1);
        checkOutput("ovf_count", int'(Count), 8);
        for (int i = 0; i < 8; i++) begin
`ifdef LINK_STACK_WRAP_EN
            checkOutput("drain_top", int'(DOut), 9 - i);
`else
            checkOutput("drain_top", int'(DOut), 8 - i);
`endif
            applyStimulus(0, 1, 8'h00, 0, 1);
        end
        checkState("drained", 0, 0);

        // Underflow and sticky clear
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkOutput("unf_set", int'(Underflow), 1);
        checkOutput("unf_count", int'(Count), 0);
        applyStimulus(0, 0, 8'h00, 1, 1);
        checkOutput("unf_clr", int'(Underflow), 0);
        checkOutput("ovf_clr", int'(Overflow), 0);
        applyStimulus(0, 1, 8'h00, 1, 1);
        checkOutput("unf_clr_wins", int'(Underflow), 1);
        applyStimulus(0, 0, 8'h00, 1, 1);

        // Replace top
        applyStimulus(1, 0, 8'h33, 0, 1);
        applyStimulus(1, 0, 8'h44, 0, 1);
        checkState("pre_replace", 2, 8'h44);
        applyStimulus(1, 1, 8'h55, 0, 1);
        checkState("replace", 2, 8'h55);
        checkOutput("replace_unf", int'(Underflow), 0);
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkState("after_replace", 1, 8'h33);

        // Reset wins over a push
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'(8'h61 + i), 0, 1);
        end
        checkState("count5", 5, 8'h64);
        applyStimulus(1, 0, 8'h77, 0, 0);
        checkState("reset_push", 0, 0);
        checkOutput("reset_push_empty", int'(Empty), 1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkState("post_reset", 0, 0);

        // Randomized traffic with alternating fill/drain bias
        bias = 70;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 150) == 0) begin
                bias = (bias == 70) ? 30 : 70;
            end
            applyStimulus($urandom_range(0, 99) < bias,
                          $urandom_range(0, 99) < (100 - bias),
                          8'($urandom_range(0, 255)),
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 127) != 0);
        end

        applyStimulus(0, 0, 8'h00, 0, 1);
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
